// File: rtl/shift_rotate_unit.sv
// Multi-cycle shift/rotate unit: SHR, SHRA, SHL, ROR, ROL, moving up to STEP bits per cycle
// under a start/busy/done handshake. Operands are latched when start is accepted.
module shift_rotate_unit #(
  parameter int WIDTH = 32,
  parameter int STEP  = 4
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic [4:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             err
);

  localparam int AW = $clog2(WIDTH);
  localparam logic [AW:0] STEP_W  = (AW+1)'(STEP);
  localparam logic [AW:0] WIDTH_W = (AW+1)'(WIDTH);

  localparam logic [4:0] OP_SHR  = 5'b00100;
  localparam logic [4:0] OP_SHRA = 5'b00101;
  localparam logic [4:0] OP_SHL  = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [AW-1:0]    amt;
  logic [4:0]       op;

  logic [AW-1:0]    k;
  logic [AW-1:0]    lsb_idx;
  logic [AW-1:0]    msb_idx;
  logic [WIDTH-1:0] next_acc;
  logic             step_out;
  logic             opcode_legal;
  logic             b_unused;

  // Only the low AW bits of the amount matter; the rest is deliberately ignored.
  assign b_unused = ^b[WIDTH-1:AW];

  assign opcode_legal = (opcode == OP_SHR) || (opcode == OP_SHRA) || (opcode == OP_SHL) ||
                        (opcode == OP_ROR) || (opcode == OP_ROL);

  // One RUN step. step_out is the bit that leaves the word in this step; on the final
  // step it is exactly the carry-out reported for the whole operation.
  always_comb begin
    k        = ({1'b0, amt} <= STEP_W) ? amt : STEP_W[AW-1:0];
    lsb_idx  = k - AW'(1);
    msb_idx  = AW'(WIDTH_W - {1'b0, k});
    next_acc = acc;
    step_out = 1'b0;
    case (op)
      OP_SHR: begin
        next_acc = acc >> k;
        step_out = acc[lsb_idx];
      end
      OP_SHRA: begin
        next_acc = $unsigned($signed(acc) >>> k);
        step_out = acc[lsb_idx];
      end
      OP_SHL: begin
        next_acc = acc << k;
        step_out = acc[msb_idx];
      end
      OP_ROR: begin
        next_acc = (acc >> k) | (acc << (WIDTH_W - {1'b0, k}));
        step_out = next_acc[WIDTH-1];
      end
      OP_ROL: begin
        next_acc = (acc << k) | (acc >> (WIDTH_W - {1'b0, k}));
        step_out = next_acc[0];
      end
      default: begin
        next_acc = acc;
        step_out = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state  <= IDLE;
      acc    <= '0;
      amt    <= '0;
      op     <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      cout   <= 1'b0;
      err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            acc  <= a;
            amt  <= b[AW-1:0];
            op   <= opcode;
            busy <= 1'b1;
            // Illegal opcodes and zero amounts finish without any RUN cycles.
            if (!opcode_legal || (b[AW-1:0] == '0)) begin
              state  <= DONE;
              done   <= 1'b1;
              result <= a;
              cout   <= 1'b0;
              err    <= !opcode_legal;
            end else begin
              state <= RUN;
              err   <= 1'b0;
            end
          end
        end
        RUN: begin
          acc <= next_acc;
          amt <= amt - k;
          if (amt == k) begin
            state  <= DONE;
            done   <= 1'b1;
            result <= next_acc;
            cout   <= step_out;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/shift_rotate_unit.md
Name: shift_rotate_unit

Overview:
Parametrised multi-cycle shift/rotate unit for the CPU datapath. It generalises the single-cycle ROR path of the ALU to SHR, SHRA, SHL, ROR and ROL at any power-of-2 word width. Each cycle it shifts by up to STEP bits, under a start/busy/done handshake. It sits beside the ALU: operand A comes from Y, operand B (the shift amount) comes from the bus, and the result is written into Z-low by the control unit when done pulses.

Parameters:
WIDTH, 32, data width; power of 2, at least 8. Local AW = log2(WIDTH).
STEP, 4, maximum bits shifted per cycle; power of 2, 1..WIDTH.

Ports:
clock  in  1  system clock, rising-edge.
clear  in  1  asynchronous, active-low reset.
start  in  1  request; sampled only in IDLE.
opcode  in  5  operation select: SHR=00100, SHRA=00101, SHL=00110, ROR=00111, ROL=01000.
a  in  WIDTH  operand to shift.
b  in  WIDTH  shift amount; only b[AW-1:0] is used.
busy  out  1  high in RUN and DONE.
done  out  1  one-cycle pulse; result is valid.
result  out  WIDTH  final value; held from done until the next accepted start.
cout  out  1  last bit shifted out (see Behaviour).
err  out  1  high with done when the opcode is unsupported.

Behaviour:
- Reset (clear=0, asynchronous):
  - state returns to IDLE.
  - busy, done, err and cout are 0.
  - result is 0.
  - Internal accumulator, amount and opcode registers are cleared.
  - Reset mid-RUN abandons the operation; no done is produced.
- States:
  - IDLE:
    - On start=1, latch acc=a, amt=b[AW-1:0], op=opcode.
    - If op is illegal or amt==0, go to DONE; otherwise go to RUN.
    - start=0 keeps the state in IDLE.
  - RUN, per edge:
    - k = min(amt, STEP).
    - acc = op(acc, k); amt = amt - k.
    - Go to DONE when the new amt==0.
  - DONE: lasts exactly one cycle, then returns to IDLE.
- Output timing:
  - result, cout and err are registered on the edge that enters DONE.
  - done=1 only while in DONE.
- Latency: with start sampled at edge E0 and N = ceil(amt/STEP), done is high in the cycle after edge E0+N.
  - For amt=0 or an illegal op, N=0.
  - Next start is accepted at the edge after DONE; throughput is one op per N+2 cycles.
- start while busy is ignored. Changes to a, b and opcode after acceptance have no effect, since they are latched.
- Operations (k < WIDTH always):
  - SHR: logical right shift, zero fill.
  - SHRA: right shift with sign-bit fill from acc[WIDTH-1].
  - SHL: left shift, zero fill.
  - ROR: rotate right.
  - ROL: rotate left.
  - Amount is mod WIDTH by construction, so rotating by 0 is the identity.
- cout:
  - SHR/SHRA: the last bit shifted out the LSB end, i.e. bit amt-1 of the original a.
  - SHL: original a[WIDTH-amt].
  - ROR: result[WIDTH-1].
  - ROL: result[0].
  - 0 when amt==0 or err=1.
- Illegal opcode (any value other than the five above): result=a, err=1, cout=0, done after N=0.
- err is cleared at the next accepted start and on reset.

Test Plan:
1. ROR, WIDTH=32, STEP=4, a=0x0000007F, b=0x1 -> done in the cycle after E0+1, result=0x8000003F, cout=1, err=0.
2. ROL a=0x80000001, b=0x24 (amt=4) -> result=0x00000018, cout=0, done after 1 RUN cycle; SHL a=0x00001234, b=0x20 (amt=0) -> done in the cycle after E0, result=0x00001234, cout=0.
3. SHRA a=0x80000000, b=31 -> busy held for 8 RUN cycles plus DONE, result=0xFFFFFFFF, cout=0; SHR with the same operands -> result=0x00000001, cout=0.
4. Pulse start with a different opcode and operands during RUN of test 3 -> ignored, result unchanged. Back-to-back start in the cycle after done -> accepted.
5. opcode=00011, a=0xDEADBEEF -> done in the cycle after E0, err=1, result=0xDEADBEEF, cout=0; the next legal op clears err.
6. Drive clear low mid-RUN (SHL a=0x1, b=20) -> busy, done and result go to 0 immediately with no done pulse; after release, re-issue -> result=0x00100000.
